// File: rtl/hilo_divider.sv
// hilo_divider: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces the full {HI, LO} = {remainder, quotient} word for the writeback
// path. The busy, done, result, hilo_flag and div_zero outputs are registered,
// so they trail the internal DONE state by one clock.
module hilo_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    input  logic                 cancel,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [2:0]           hilo_flag,
    output logic                 div_zero
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_FIX  = 3'd2;
    localparam logic [2:0] S_ZERO = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag_b;
    logic             sign_a;
    logic             sign_b;
    logic             zero_flag;
    logic             accept;
    logic             finish;
    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH:0]   trial;
    logic             dividend_neg;
    logic             divisor_neg;

    // Two's-complement negation of a WIDTH-bit value.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return '0 - v;
    endfunction

    // Conditional negation: magnitude for signed operands, sign restore on results.
    // A negated 0x80..0 stays 0x80..0, which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic            neg);
        return neg ? negate(v) : v;
    endfunction

    // The cycle in which the done pulse is visible has the FSM already back in
    // IDLE, so a start there must be rejected as well.
    assign accept       = (state == S_IDLE) && start && !cancel && !done;
    assign finish       = (state == S_DONE) && !cancel;
    assign dividend_neg = signed_div & dividend[WIDTH-1];
    assign divisor_neg  = signed_div & divisor[WIDTH-1];

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
    // The shifted-out remainder MSB is kept as bit WIDTH so the trial never overflows.
    assign rem_shift = {rem[WIDTH-2:0], quo[WIDTH-1]};
    assign trial     = {rem[WIDTH-1], rem_shift} - {1'b0, mag_b};

    // Next-state selection; cancel aborts every non-IDLE state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (divisor == '0) ? S_ZERO : S_CALC;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_next = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:   state_next = cancel ? S_IDLE : S_DONE;
            S_ZERO:  state_next = cancel ? S_IDLE : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM state and iteration counter (counts WIDTH down to 0 across CALC).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_W'(WIDTH);
            end else if (state == S_CALC) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Datapath: operand capture, restoring iterations and sign fix-up.
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_a    <= dividend_neg;
            sign_b    <= divisor_neg;
            zero_flag <= (divisor == '0);
            mag_b     <= cond_negate(divisor, divisor_neg);
            if (divisor == '0) begin
                rem <= dividend;
                quo <= {WIDTH{1'b1}};
            end else begin
                rem <= '0;
                quo <= cond_negate(dividend, dividend_neg);
            end
        end else if (state == S_CALC) begin
            rem <= trial[WIDTH] ? rem_shift : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
        end else if (state == S_FIX) begin
            quo <= cond_negate(quo, sign_a ^ sign_b);
            rem <= cond_negate(rem, sign_a);
        end
    end

    // Registered outputs; result only changes when a divide completes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            hilo_flag <= 3'b000;
            div_zero  <= 1'b0;
        end else begin
            busy      <= (state_next != S_IDLE) || finish;
            done      <= finish;
            hilo_flag <= finish ? 3'b111 : 3'b000;
            if (finish) begin
                result <= {rem, quo};
            end
            if (accept) begin
                div_zero <= 1'b0;
            end else if (finish) begin
                div_zero <= zero_flag;
            end
        end
    end

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: directed vectors with a scoreboard queue and a monitor
// that checks every done pulse against the oldest expected result.
module tb_hilo_divider;

    localparam int WIDTH = 32;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [2:0]  hilo_flag;
    logic        div_zero;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] last_res = '0;
    exp_t        sb[$];

    hilo_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .cancel     (cancel),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .hilo_flag  (hilo_flag),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%h required=no done", result);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e.res);
                    chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                    chk("hilo_flag", {61'd0, hilo_flag}, 64'd7);
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else if (hilo_flag != 3'b000) begin
                checks++;
                errors++;
                $display("FAIL hilo_flag_idle actual=%h required=0", hilo_flag);
            end
        end
    end

    // Issue one divide, then follow it to its done pulse.
    task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] er, input logic edz);
        int lat;
        bit seen;
        exp_t e;
        lat = (b == 32'd0) ? 2 : WIDTH + 2;
        @(negedge clk);
        start = 1'b1; signed_div = sd; dividend = a; divisor = b;
        e.res = er; e.dz = edz; e.cyc = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("div_zero_cleared", {63'd0, div_zero}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                start = 1'b1;
                signed_div = ~sd;
            end else if (i == 3) begin
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done required=done");
            start = 1'b0;
        end else begin
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_done", {63'd0, busy}, 64'd0);
            chk("single_done", {63'd0, done}, 64'd0);
            chk("result_held", result, er);
            last_res = er;
        end
    endtask

    initial begin
        int nd;
        repeat (2) @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_hilo_flag", {61'd0, hilo_flag}, 64'd0);
        chk("reset_div_zero", {63'd0, div_zero}, 64'd0);
        resetn = 1'b1;

        do_div(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        1'b0);
        do_div(1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  1'b0);
        do_div(1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD},  1'b0);
        do_div(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'd0,        32'h80000000},  1'b0);
        do_div(1'b0, 32'd5,          32'd0,        {32'd5,        32'hFFFFFFFF},  1'b1);
        do_div(1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF},  1'b0);
        do_div(1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'd0},         1'b0);
        do_div(1'b1, 32'hFFFFFFFB,   32'd0,        {32'hFFFFFFFB, 32'hFFFFFFFF},  1'b1);
        do_div(1'b0, 32'd3,          32'd10,       {32'd3,        32'd0},         1'b0);
        do_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},        1'b0);

        // Cancel in the middle of CALC.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("busy_after_cancel", {63'd0, busy}, 64'd0);
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("no_done_after_cancel", 64'(nd), 64'd0);
        chk("result_after_cancel", result, last_res);

        // start together with cancel in IDLE is not accepted.
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd2;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("start_with_cancel", {63'd0, busy}, 64'd0);

        do_div(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0);

        // Synchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; dividend = 32'd77; divisor = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_done", {63'd0, done}, 64'd0);
        chk("midreset_result", result, 64'd0);
        chk("midreset_hilo_flag", {61'd0, hilo_flag}, 64'd0);
        chk("midreset_div_zero", {63'd0, div_zero}, 64'd0);
        resetn = 1'b1;

        do_div(1'b0, 32'd77, 32'd5, {32'd2, 32'd15}, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
